obstacle_scheduler: RTL and testbench

//   Consumer side of the Random generator. Samples its 5-bit data to decide when the next

---
 rtl/dino_pkg.sv | 28 ++
 rtl/obstacle_scheduler_gap_counter.sv | 30 +++
 rtl/obstacle_scheduler.sv | 75 +++++++
 tb/tb_obstacle_scheduler.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/dino_pkg.sv
// Shared constants for the dino game datapath: obstacle kinds, Random width,
// scheduler state encoding and the obstacle-type fold.
package dino_pkg;

  localparam int RND_W = 5;

  localparam logic [1:0] OBS_CACTUS_S = 2'd0;
  localparam logic [1:0] OBS_CACTUS_L = 2'd1;
  localparam logic [1:0] OBS_BIRD     = 2'd2;

  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_LOAD_ENC  = 2'd1;
  localparam logic [1:0] ST_WAIT_ENC  = 2'd2;
  localparam logic [1:0] ST_OFFER_ENC = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_LOAD  = ST_LOAD_ENC,
    ST_WAIT  = ST_WAIT_ENC,
    ST_OFFER = ST_OFFER_ENC
  } sched_state_t;

  // Code 3 has no obstacle of its own; it folds onto the small cactus.
  function automatic logic [1:0] fold_type(input logic [1:0] r);
    return (r == 2'd3) ? OBS_CACTUS_S : r;
  endfunction

endpackage

// File: rtl/obstacle_scheduler_gap_counter.sv
// Loadable down-counter measuring the frame gap between obstacle spawns.
module gap_counter
  import dino_pkg::*;
#(
  parameter int GAP_W = 6
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             load,
  input  logic [GAP_W-1:0] load_val,
  input  logic             tick,
  output logic             expire
);

  logic [GAP_W-1:0] count;

  // Load wins over a tick in the same cycle; the count parks at zero.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expire = tick && (count == GAP_W'(1));

endmodule

// File: rtl/obstacle_scheduler.sv
// Obstacle scheduler: turns Random samples into timed spawn requests offered
// to the obstacle engine over a valid/ready handshake.
module obstacle_scheduler
  import dino_pkg::*;
#(
  parameter int MIN_GAP = 8,
  parameter int GAP_W   = 6,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             run,
  input  logic             frame_tick,
  input  logic [RND_W-1:0] rnd_data,
  output logic             spawn_valid,
  input  logic             spawn_ready,
  output logic [1:0]       spawn_type,
  output logic [GAP_W-1:0] spawn_gap,
  output logic [CNT_W-1:0] spawn_count
);

  sched_state_t     state, state_n;
  logic [GAP_W-1:0] gap;
  logic             load, tick_wait, expire, accept;

  assign gap       = GAP_W'(MIN_GAP) + GAP_W'(rnd_data);
  assign load      = run && (state == ST_LOAD);
  assign tick_wait = frame_tick && (state == ST_WAIT);
  // run low overrides a handshake that lands on the same edge.
  assign accept    = run && spawn_valid && spawn_ready;

  gap_counter #(.GAP_W(GAP_W)) u_gap (
    .clk      (clk),
    .RESET    (RESET),
    .load     (load),
    .load_val (gap),
    .tick     (tick_wait),
    .expire   (expire)
  );

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  state_n = ST_LOAD;
      ST_LOAD:  state_n = ST_WAIT;
      ST_WAIT:  if (expire) state_n = ST_OFFER;
      ST_OFFER: if (accept) state_n = ST_LOAD;
      default:  state_n = ST_IDLE;
    endcase
    if (!run) state_n = ST_IDLE;
  end

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      spawn_valid <= 1'b0;
      spawn_type  <= OBS_CACTUS_S;
      spawn_gap   <= '0;
      spawn_count <= '0;
    end else begin
      spawn_valid <= (state_n == ST_OFFER);
      if (load) spawn_gap <= gap;
      if (run && expire) spawn_type <= fold_type(rnd_data[1:0]);
      if (accept) spawn_count <= spawn_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Directed bench for obstacle_scheduler with hand-computed gaps, types and counts.
module tb_obstacle_scheduler;

  logic       clk;
  logic       RESET;
  logic       run;
  logic       frame_tick;
  logic [4:0] rnd_data;
  logic       spawn_valid;
  logic       spawn_ready;
  logic [1:0] spawn_type;
  logic [5:0] spawn_gap;
  logic [7:0] spawn_count;

  int n_chk  = 0;
  int n_pass = 0;

  obstacle_scheduler #(.MIN_GAP(8), .GAP_W(6), .CNT_W(8)) dut (
    .clk         (clk),
    .RESET       (RESET),
    .run         (run),
    .frame_tick  (frame_tick),
    .rnd_data    (rnd_data),
    .spawn_valid (spawn_valid),
    .spawn_ready (spawn_ready),
    .spawn_type  (spawn_type),
    .spawn_gap   (spawn_gap),
    .spawn_count (spawn_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Precondition: the next edge is the LOAD edge. Leaves the DUT in OFFER with valid=1.
  task automatic spawn(input logic [4:0] r, input int g, input logic [4:0] r_ofr,
                       input logic [1:0] etype);
    rnd_data = r;
    step();
    chk("gap_loaded", spawn_gap, g);
    rnd_data = r_ofr;
    for (int i = 1; i < g; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      chk("valid_early", spawn_valid, 0);
      step();
    end
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    chk("valid_rise", spawn_valid, 1);
    chk("type", spawn_type, etype);
  endtask

  // Completes the handshake; afterwards the DUT sits in LOAD.
  task automatic accept(input int ecount);
    spawn_ready = 1'b1;
    step();
    spawn_ready = 1'b0;
    chk("valid_fall", spawn_valid, 0);
    chk("count", spawn_count, ecount);
  endtask

  initial begin
    RESET = 1'b1; run = 1'b0; frame_tick = 1'b0; rnd_data = 5'd0; spawn_ready = 1'b0;
    #2 RESET = 1'b0;
    repeat (2) step();
    chk("rst_valid", spawn_valid, 0);
    chk("rst_type", spawn_type, 0);
    chk("rst_gap", spawn_gap, 0);
    chk("rst_count", spawn_count, 0);
    RESET = 1'b1;
    step();

    // Nominal spawn: gap 8+5=13, ready high at offer.
    run = 1'b1;
    step();
    spawn(5'd5, 13, 5'b00001, 2'd1);
    accept(1);

    // Async reset in the middle of WAIT.
    rnd_data = 5'd5;
    step();
    for (int i = 0; i < 3; i++) begin
      frame_tick = 1'b1; step(); frame_tick = 1'b0; step();
    end
    #3 RESET = 1'b0;
    run = 1'b0;
    #1;
    chk("arst_valid", spawn_valid, 0);
    chk("arst_type", spawn_type, 0);
    chk("arst_gap", spawn_gap, 0);
    chk("arst_count", spawn_count, 0);
    repeat (3) @(posedge clk);
    #2;
    chk("arst_hold_gap", spawn_gap, 0);
    chk("arst_hold_type", spawn_type, 0);
    RESET = 1'b1;
    step();

    // Gap bounds.
    run = 1'b1;
    step();
    spawn(5'd0, 8, 5'b00010, 2'd2);
    accept(1);
    spawn(5'd31, 39, 5'b00011, 2'd0);
    accept(2);

    // Backpressure with ticks and changing rnd_data.
    spawn(5'd7, 15, 5'b10001, 2'd1);
    for (int i = 0; i < 10; i++) begin
      rnd_data = 5'(i * 3 + 2);
      frame_tick = (i % 2 == 0);
      step();
      chk("bp_valid", spawn_valid, 1);
      chk("bp_type", spawn_type, 1);
      chk("bp_count", spawn_count, 2);
    end
    frame_tick = 1'b0;
    accept(3);

    // run dropped in OFFER together with ready.
    spawn(5'd2, 10, 5'b00010, 2'd2);
    spawn_ready = 1'b1;
    run = 1'b0;
    step();
    spawn_ready = 1'b0;
    chk("abort_valid", spawn_valid, 0);
    chk("abort_count", spawn_count, 3);
    chk("abort_type", spawn_type, 2);
    chk("abort_gap", spawn_gap, 10);
    step();
    chk("idle_valid", spawn_valid, 0);
    run = 1'b1;
    step();
    spawn(5'd9, 17, 5'b00100, 2'd0);
    accept(4);

    // Fold of code 3 and statistic wrap after 256 accepts.
    for (int n = 5; n <= 256; n++) begin
      spawn(5'd0, 8, 5'b11111, 2'd0);
      accept(n % 256);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
